// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types for the trace capture path: one retired-instruction record as
// it travels from the trace filter to the DMA stream.
package continuous_monitoring_system_pkg;

  localparam int TRACE_ITEM_WIDTH = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_item_t;

endpackage

// File: rtl/trace_item_fifo.sv
// Item buffer for the trace packer. Head entry is read from the register
// array through the registered read pointer; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module trace_item_fifo
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  trace_item_t              wr_data,
  input  logic                     rd_en,
  output trace_item_t              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  trace_item_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trace_stream_packer.sv
// Captures instructions kept by the trace filter, buffers them and streams
// them out as AXI-Stream packets, with host flush and lost-item accounting.
module trace_stream_packer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int FIFO_DEPTH         = 16,
  parameter int PACKET_ITEMS       = 64,
  parameter int LOST_COUNTER_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            pc_valid,
  input  logic [31:0]                     pc,
  input  logic [31:0]                     instr,
  input  logic                            drop_instr,
  input  logic                            flush,
  input  logic                            clear_lost,
  output logic [63:0]                     m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [LOST_COUNTER_WIDTH-1:0]   lost_count,
  output logic                            overflow
);

  localparam int LVW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW  = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_ITEMS - 1);

  function automatic logic [LOST_COUNTER_WIDTH-1:0] sat_inc(
    input logic [LOST_COUNTER_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  trace_item_t     item_p0;
  trace_item_t     head_p0;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LVW-1:0]  level_p0;
  logic            write_req;
  logic            write;
  logic            load;
  logic            lost;
  logic            flush_accept;
  logic            last_next;

  trace_item_t     item_p1;
  logic            last_p1;
  logic            vld_p1;
  logic [BW-1:0]   beat_count;
  logic            flush_pending;

  // p0: capture into the item buffer
  assign item_p0   = '{instr: instr, pc: pc};
  assign write_req = en && pc_valid && !drop_instr;
  assign load      = !fifo_empty && (!vld_p1 || m_axis_tready);
  assign write     = write_req && (!fifo_full || load);
  assign lost      = write_req && !write;

  trace_item_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (write),
    .wr_data (item_p0),
    .rd_en   (load),
    .rd_data (head_p0),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_p0)
  );

  // A flush with nothing buffered and no partial packet has nothing to close.
  assign flush_accept = flush && !((beat_count == '0) && fifo_empty);
  assign last_next    = (beat_count == LAST_BEAT) ||
                        ((flush_pending || flush_accept) &&
                         (level_p0 == LVW'(1)) && !write);

  // p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      item_p1       <= '0;
      last_p1       <= 1'b0;
      vld_p1        <= 1'b0;
      beat_count    <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (load) begin
        item_p1    <= head_p0;
        last_p1    <= last_next;
        vld_p1     <= 1'b1;
        beat_count <= last_next ? '0 : beat_count + 1'b1;
      end else if (vld_p1 && m_axis_tready) begin
        vld_p1 <= 1'b0;
      end

      if (load && last_next) flush_pending <= 1'b0;
      else if (flush_accept) flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_count <= '0;
      overflow   <= 1'b0;
    end else if (lost) begin
      lost_count <= clear_lost ? LOST_COUNTER_WIDTH'(1) : sat_inc(lost_count);
      overflow   <= 1'b1;
    end else if (clear_lost) begin
      lost_count <= '0;
      overflow   <= 1'b0;
    end
  end

  assign m_axis_tdata  = item_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tvalid = vld_p1;
  assign fifo_level    = level_p0;

endmodule

// File: tb/tb_trace_stream_packer.sv
// Scoreboard bench for trace_stream_packer: a queue-based model predicts the
// beat stream and status outputs; a negedge monitor compares against the DUT.
module tb_trace_stream_packer;

  localparam int D   = 4;
  localparam int P   = 4;
  localparam int LCW = 3;
  localparam int LVW = $clog2(D) + 1;
  localparam int LMAX = (1 << LCW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0, pc_valid = 1'b0, drop_instr = 1'b0;
  logic            flush = 1'b0, clear_lost = 1'b0, m_axis_tready = 1'b0;
  logic [31:0]     pc = '0, instr = '0;
  logic [63:0]     m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, overflow;
  logic [LVW-1:0]  fifo_level;
  logic [LCW-1:0]  lost_count;

  always #5 clk = ~clk;

  trace_stream_packer #(
    .FIFO_DEPTH(D), .PACKET_ITEMS(P), .LOST_COUNTER_WIDTH(LCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_valid(pc_valid), .pc(pc),
    .instr(instr), .drop_instr(drop_instr), .flush(flush),
    .clear_lost(clear_lost), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .fifo_level(fifo_level),
    .lost_count(lost_count), .overflow(overflow)
  );

  int ncmp = 0;
  int nerr = 0;

  // Model: buffered items, output slot, packet position, flush state, losses.
  logic [63:0] mfifo[$];
  logic [64:0] expq[$];
  bit m_ovalid, m_fpend, m_ovf;
  int m_beats, m_lost;
  bit s_tvalid, s_ovf;
  int s_level, s_lost;
  bit chk_en = 1'b0;

  bit          mon_stall = 1'b0;
  logic [63:0] mon_data;
  logic        mon_last;
  logic [64:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfifo.delete(); expq.delete();
    m_ovalid = 0; m_fpend = 0; m_ovf = 0; m_beats = 0; m_lost = 0;
    s_tvalid = 0; s_ovf = 0; s_level = 0; s_lost = 0;
  endtask

  task automatic model_step();
    bit empty, pop, req, wr, flush_ok, last;
    logic [63:0] item;
    empty    = (mfifo.size() == 0);
    pop      = !empty && (!m_ovalid || m_axis_tready);
    req      = en && pc_valid && !drop_instr;
    wr       = req && (mfifo.size() < D || pop);
    flush_ok = flush && !(m_beats == 0 && empty);
    if (pop) begin
      item = mfifo.pop_front();
      last = (m_beats == P - 1) || ((m_fpend || flush_ok) && mfifo.size() == 0 && !wr);
      expq.push_back({last, item});
      m_beats  = last ? 0 : m_beats + 1;
      m_ovalid = 1;
      if (last) m_fpend = 0;
      else if (flush_ok) m_fpend = 1;
    end else begin
      if (m_ovalid && m_axis_tready) m_ovalid = 0;
      if (flush_ok) m_fpend = 1;
    end
    if (wr) mfifo.push_back({instr, pc});
    if (req && !wr) begin
      m_lost = clear_lost ? 1 : ((m_lost + 1 > LMAX) ? LMAX : m_lost + 1);
      m_ovf  = 1;
    end else if (clear_lost) begin
      m_lost = 0;
      m_ovf  = 0;
    end
  endtask

  task automatic cyc(input bit e, input bit v, input bit d, input bit f,
                     input bit c, input bit r);
    @(posedge clk); #1;
    en = e; pc_valid = v; drop_instr = d; flush = f; clear_lost = c;
    m_axis_tready = r; pc = $urandom; instr = $urandom;
    s_tvalid = m_ovalid; s_level = mfifo.size(); s_lost = m_lost; s_ovf = m_ovf;
    model_step();
  endtask

  task automatic keep(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, r);
  endtask

  task automatic drain();
    int n = 0;
    while ((mfifo.size() != 0 || m_ovalid) && n < 100) begin
      idle(1, 1);
      n++;
    end
    idle(2, 1);
    check("drain_bound", 64'(n < 100), 64'(1));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!chk_en || !rst_n) begin
        mon_stall = 0;
        continue;
      end
      check("tvalid", 64'(m_axis_tvalid), 64'(s_tvalid));
      check("fifo_level", 64'(fifo_level), 64'(s_level));
      check("lost_count", 64'(lost_count), 64'(s_lost));
      check("overflow", 64'(overflow), 64'(s_ovf));
      if (mon_stall && m_axis_tvalid) begin
        check("stall_tdata", m_axis_tdata, mon_data);
        check("stall_tlast", 64'(m_axis_tlast), 64'(mon_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL beat: unexpected beat %h, none expected", m_axis_tdata);
        end else begin
          mon_exp = expq.pop_front();
          check("tdata", m_axis_tdata, mon_exp[63:0]);
          check("tlast", 64'(m_axis_tlast), 64'(mon_exp[64]));
        end
      end
      mon_stall = m_axis_tvalid && !m_axis_tready;
      mon_data  = m_axis_tdata;
      mon_last  = m_axis_tlast;
    end
  end

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_tdata", m_axis_tdata, 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_lost", 64'(lost_count), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;

    // packet boundary: 8 items back to back
    keep(8, 1);
    drain();

    // filtering: alternate drop/keep over 10 items
    for (int i = 0; i < 10; i++) cyc(1, 1, (i % 2) == 0, 0, 0, 1);
    drain();

    // back-pressure and loss
    keep(7, 0);
    idle(3, 0);
    drain();
    cyc(0, 0, 0, 0, 1, 1);
    idle(1, 1);

    // flush closes a partial packet; a flush with nothing pending is ignored
    keep(3, 1);
    cyc(0, 0, 0, 1, 0, 1);
    drain();
    cyc(0, 0, 0, 1, 0, 1);
    keep(4, 1);
    drain();

    // deferred flush: applies to the next item after an idle gap
    keep(2, 1);
    drain();
    cyc(0, 0, 0, 1, 0, 1);
    idle(5, 1);
    keep(1, 1);
    drain();

    // saturation of the lost counter, then clear racing a loss
    keep(14, 0);
    cyc(1, 1, 0, 0, 1, 0);
    idle(2, 0);
    drain();
    cyc(0, 0, 0, 0, 1, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
          ($urandom % 20) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0);
    drain();

    // asynchronous reset while a beat is stalled mid-packet
    keep(2, 1);
    keep(3, 0);
    @(posedge clk); #1;
    en = 0; pc_valid = 0; flush = 0; clear_lost = 0; m_axis_tready = 0;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("async_rst_level", 64'(fifo_level), 64'(0));
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    keep(5, 1);
    drain();

    check("all_beats_seen", 64'(expq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
